// File: rtl/sys_tx_queue_pkg.sv
// Shared definitions for the TX byte queue: sequencer state encoding and
// default sizing constants.
package sys_tx_queue_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 8;
  localparam int unsigned DEPTH_DEF        = 8;
  localparam int unsigned BUSY_TIMEOUT_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LAUNCH    = 2'b01,
    ST_WAIT_BUSY = 2'b10,
    ST_WAIT_DONE = 2'b11
  } tx_state_e;

endpackage

// File: rtl/sys_tx_queue_fifo_core.sv
// sync_fifo_core: single-clock register-array FIFO with extended pointers.
// One extra pointer bit distinguishes full from empty when the indexes match.
module sync_fifo_core
  import sys_tx_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_W:0]       level_o
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status is derived purely from the registered pointers.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  assign wr_acc    = wr_en_i && !full_o;
  assign rd_acc    = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // Pointer advance for accepted writes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_acc);
  end

  // Pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/sys_tx_queue.sv
// sys_tx_queue: byte queue plus transmit sequencer. Launches one byte per
// UART frame, waiting for the busy flag to rise and fall between bytes, and
// flags a launch whose busy flag never rose.
// Optional build macro SYS_TX_QUEUE_DROP_CNT_EN adds a saturating DROP_CNT
// output counting writes dropped while full.
module sys_tx_queue
  import sys_tx_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned ADDR_W       = $clog2(DEPTH),
  parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [ADDR_W:0]       LEVEL,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VLD,
  input  logic                  TX_BUSY,
  output logic                  TIMEOUT
`ifdef SYS_TX_QUEUE_DROP_CNT_EN
  ,
  output logic [7:0]            DROP_CNT
`endif
);

  localparam int unsigned      CNT_W    = $clog2(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  timeout_q, timeout_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic [ADDR_W:0]       fifo_level;

  // The head byte leaves the queue during the launch cycle.
  assign fifo_pop = (state_q == ST_LAUNCH);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  sync_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (WR_EN),
    .wr_data_i (WR_DATA),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign FULL    = fifo_full;
  assign EMPTY   = fifo_empty;
  assign LEVEL   = fifo_level;
  assign TX_DATA = tx_data_q;
  assign TX_VLD  = tx_vld_q;
  assign TIMEOUT = timeout_q;

  // Sequencer state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: launch only onto an idle transmitter, then track rise/fall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !TX_BUSY) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (TX_BUSY) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_inc == CNT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!TX_BUSY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/next-value logic for the registered outputs and busy-wait counter.
  always_comb begin
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    timeout_d = 1'b0;
    if (state_d == ST_LAUNCH) begin
      tx_vld_d  = 1'b1;
      tx_data_d = fifo_rd_data;
    end
    case (state_q)
      ST_LAUNCH: cnt_d = '0;
      ST_WAIT_BUSY: begin
        cnt_d = cnt_inc;
        if (!TX_BUSY && (cnt_inc == CNT_LAST)) timeout_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs and counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef SYS_TX_QUEUE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of writes refused because the queue was full.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (WR_EN && fifo_full && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register; cleared only by reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sys_tx_queue.sv
// Scoreboard bench for sys_tx_queue: writes push expected bytes, a negedge
// monitor pops them on each launch and checks framing, timeout and level.
module tb_sys_tx_queue;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned BT    = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] WR_DATA;
  logic          WR_EN;
  logic          FULL;
  logic          EMPTY;
  logic [AW:0]   LEVEL;
  logic [DW-1:0] TX_DATA;
  logic          TX_VLD;
  logic          TX_BUSY;
  logic          TIMEOUT;
`ifdef SYS_TX_QUEUE_DROP_CNT_EN
  logic [7:0]    DROP_CNT;
`endif

  logic man_busy;
  logic auto_busy;
  logic auto_en;
  assign TX_BUSY = man_busy | auto_busy;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  sys_tx_queue #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .WR_DATA (WR_DATA),
    .WR_EN   (WR_EN),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .LEVEL   (LEVEL),
    .TX_DATA (TX_DATA),
    .TX_VLD  (TX_VLD),
    .TX_BUSY (TX_BUSY),
    .TIMEOUT (TIMEOUT)
`ifdef SYS_TX_QUEUE_DROP_CNT_EN
    ,
    .DROP_CNT (DROP_CNT)
`endif
  );

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Reference model: a byte queue with capacity DEPTH.
  logic [DW-1:0] exp_q[$];
  int   mlevel = 0;
  int   mdrops = 0;
  logic vld_prev = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_q.delete();
      mlevel = 0;
      mdrops = 0;
    end else begin
      if (WR_EN) begin
        if (mlevel < DEPTH) begin
          exp_q.push_back(WR_DATA);
          mlevel++;
        end else if (mdrops < 255) begin
          mdrops++;
        end
      end
      if (vld_prev) mlevel--;
    end
  end

  // Monitor: status, launch ordering/legality and timeout framing.
  logic outstanding = 1'b0;
  logic rose = 1'b0;
  logic busy_prev = 1'b0;
  int   since_vld = 0;

  always @(negedge CLK) begin
    logic ok_launch;
    logic [DW-1:0] e;
    if (RST) begin
      outstanding = 1'b0;
      rose        = 1'b0;
      vld_prev    = 1'b0;
      since_vld   = 0;
      busy_prev   = TX_BUSY;
    end else begin
      chk("level", LEVEL, mlevel);
      chk("full", FULL, (mlevel == DEPTH) ? 1 : 0);
      chk("empty", EMPTY, (mlevel == 0) ? 1 : 0);
      ok_launch = !outstanding && !busy_prev;
      if (outstanding) since_vld++;
      chk("timeout_pulse", TIMEOUT, (outstanding && !rose && since_vld == BT) ? 1 : 0);
      if (outstanding) begin
        if (!rose && since_vld == BT) begin
          outstanding = 1'b0;
        end else if (rose && !TX_BUSY) begin
          outstanding = 1'b0;
        end else if (!rose && TX_BUSY && since_vld >= 1 && since_vld <= BT - 1) begin
          rose = 1'b1;
        end
      end
      if (TX_VLD) begin
        chk("launch_legal", ok_launch, 1);
        if (exp_q.size() == 0) begin
          chk("launch_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", TX_DATA, e);
        end
        outstanding = 1'b1;
        rose        = 1'b0;
        since_vld   = 0;
      end
      vld_prev  = TX_VLD;
      busy_prev = TX_BUSY;
    end
  end

  // UART stand-in: answers each launch with a busy frame of random shape.
  initial begin
    auto_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (auto_en && TX_VLD && !RST) begin
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1 auto_busy = 1'b1;
        repeat ($urandom_range(2, 6)) @(posedge CLK);
        #1 auto_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_byte(input logic [DW-1:0] b);
    WR_DATA = b;
    WR_EN   = 1'b1;
    tick();
    WR_EN   = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_vld"}, TX_VLD, 0);
    chk({tag, "_to"}, TIMEOUT, 0);
    chk({tag, "_data"}, TX_DATA, 0);
    chk({tag, "_level"}, LEVEL, 0);
    chk({tag, "_empty"}, EMPTY, 1);
    chk({tag, "_full"}, FULL, 0);
`ifdef SYS_TX_QUEUE_DROP_CNT_EN
    chk({tag, "_drop"}, DROP_CNT, 0);
`endif
  endtask

  task automatic wait_drain(input string name, input int bound);
    int  n = 0;
    bit  done = 1'b0;
    while (!done && n < bound) begin
      if (exp_q.size() == 0 && mlevel == 0 && !outstanding && !TX_BUSY) done = 1'b1;
      else begin
        @(negedge CLK);
        n++;
      end
    end
    chk({name, "_drained"}, done, 1);
    tick();
  endtask

  task automatic wait_vld(input string name);
    int n = 0;
    @(negedge CLK);
    while (!TX_VLD && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_vld_seen"}, TX_VLD, 1);
  endtask

  initial begin
    int n;
    WR_EN    = 1'b0;
    WR_DATA  = '0;
    man_busy = 1'b0;
    auto_en  = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check_reset("rst0");
    RST = 1'b0;
    tick();

    // Basic launch and two-edge latency
    write_byte(8'hA5);
    @(negedge CLK); chk("lat_early", TX_VLD, 0);
    @(negedge CLK); chk("lat_vld", TX_VLD, 1); chk("lat_data", TX_DATA, 8'hA5);
    @(negedge CLK); chk("vld_single", TX_VLD, 0); chk("basic_level", LEVEL, 0);
    tick();
    man_busy = 1'b1;
    repeat (10) tick();
    man_busy = 1'b0;
    repeat (3) tick();
    chk("basic_data_hold", TX_DATA, 8'hA5);

    // Fill and overflow while the transmitter is busy
    auto_en  = 1'b1;
    man_busy = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) write_byte(8'(i));
    @(negedge CLK);
    chk("fill_full", FULL, 1);
    chk("fill_level", LEVEL, 8);
`ifdef SYS_TX_QUEUE_DROP_CNT_EN
    chk("fill_drop", DROP_CNT, 1);
`endif
    repeat (5) @(negedge CLK);
    chk("busy_hold_level", LEVEL, 8);

    // Ordered drain
    tick();
    man_busy = 1'b0;
    wait_drain("drain", 1000);
    chk("drain_empty", EMPTY, 1);

    // Busy timeout
    auto_en = 1'b0;
    write_byte(8'h3C);
    wait_vld("to");
    n = 0;
    @(negedge CLK);
    n++;
    while (!TIMEOUT && n < 2 * BT) begin
      @(negedge CLK);
      n++;
    end
    chk("to_distance", n, BT);
    tick();
    auto_en = 1'b1;
    write_byte(8'h3D);
    wait_drain("after_to", 200);

    // Simultaneous write and pop at level 3
    man_busy = 1'b1;
    write_byte(8'h51);
    write_byte(8'h52);
    write_byte(8'h53);
    @(negedge CLK);
    chk("sim_level_pre", LEVEL, 3);
    tick();
    man_busy = 1'b0;
    wait_vld("sim");
    WR_DATA = 8'h54;
    WR_EN   = 1'b1;
    @(posedge CLK);
    #1 WR_EN = 1'b0;
    @(negedge CLK);
    chk("sim_level_post", LEVEL, 3);
    tick();
    wait_drain("sim", 500);

    // Reset mid-frame
    auto_en = 1'b0;
    for (int i = 0; i < 5; i++) write_byte(8'(8'h61 + i));
    man_busy = 1'b1;
    repeat (3) tick();
    @(negedge CLK);
    chk("mid_level", LEVEL, 4);
    tick();
    RST = 1'b1;
    #1;
    check_reset("rst_mid");
    repeat (2) tick();
    RST      = 1'b0;
    man_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("post_rst_quiet", TX_VLD, 0);
    end
    tick();

    // Randomised traffic with a responsive UART
    auto_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      WR_EN   = ($urandom_range(0, 99) < 30);
      WR_DATA = 8'($urandom);
      tick();
    end
    WR_EN = 1'b0;
    wait_drain("random", 3000);
    chk("final_empty", EMPTY, 1);
`ifdef SYS_TX_QUEUE_DROP_CNT_EN
    chk("final_drop", DROP_CNT, mdrops);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound on the whole run.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sys_tx_queue.md
Name: sys_tx_queue

Overview:
- Single-clock byte queue and transmit sequencer in the REF_CLK domain, between the system controller's TX output and the TX-domain data synchronizer.
- Buffers response bytes, e.g. ALU 16-bit results split into two bytes or register read-backs.
- Launches one byte at a time as a single-cycle valid pulse, only when the synchronized UART busy flag shows the transmitter idle.
- Tracks each frame through busy-rise and busy-fall before launching the next byte.

Parameters:
- DATA_WIDTH, 8, byte width.
- DEPTH, 8, queue entries; power of 2, ≥2.
- ADDR_W, $clog2(DEPTH), pointer width (derived).
- BUSY_TIMEOUT, 32, cycles allowed for the busy flag to rise after a launch; ≥4.

Ports:
- CLK  in  1  reference clock.
- RST  in  1  asynchronous, active-high reset.
- WR_DATA  in  DATA_WIDTH  byte from the system controller.
- WR_EN  in  1  write strobe; one byte per cycle.
- FULL  out  1  queue full.
- EMPTY  out  1  queue empty.
- LEVEL  out  ADDR_W+1  occupied entries.
- TX_DATA  out  DATA_WIDTH  byte to the TX data synchronizer.
- TX_VLD  out  1  one-cycle launch pulse.
- TX_BUSY  in  1  synchronized UART busy flag.
- TIMEOUT  out  1  one-cycle pulse: busy never rose after a launch.

Behaviour:
- **Reset values (async, RST=1):** pointers=0, LEVEL=0, EMPTY=1, FULL=0, TX_DATA=0, TX_VLD=0, TIMEOUT=0, state=IDLE, timeout counter=0.
- **Storage and pointers:**
  - Storage is a DEPTH-entry register array.
  - Write and read pointers are ADDR_W+1 bits wide; the index wraps naturally at DEPTH.
  - EMPTY when pointers are equal.
  - FULL when indexes are equal and the MSBs differ.
  - LEVEL = wr_ptr − rd_ptr, modulo 2^(ADDR_W+1).
- **Write rules:**
  - A write is accepted when WR_EN=1 and FULL=0.
  - WR_EN while FULL is dropped, even if a pop occurs in the same cycle; FULL is evaluated from registered state.
  - A simultaneous accepted write and pop leaves LEVEL unchanged.
- **FSM, 4 states, all outputs registered:**
  - IDLE: if !EMPTY && !TX_BUSY → LAUNCH.
  - LAUNCH (1 cycle):
    - TX_DATA ← mem[rd_idx]; TX_VLD=1; rd_ptr++; counter cleared.
    - Next state is WAIT_BUSY.
    - TX_DATA holds its value until the next LAUNCH.
  - WAIT_BUSY:
    - Counter increments each cycle.
    - TX_BUSY=1 → WAIT_DONE.
    - Counter reaches BUSY_TIMEOUT−1 with TX_BUSY=0 → pulse TIMEOUT for 1 cycle and go to IDLE. The byte is considered consumed and is not re-sent.
  - WAIT_DONE: TX_BUSY=0 → IDLE.
- **Latency:** a byte written at edge k into an empty queue, with TX_BUSY=0, sees TX_VLD high during the cycle after edge k+1.
- **Back-to-back bytes:** each requires a full busy rise/fall cycle, so bytes are never overlapped.
- **TX_BUSY high in IDLE** (e.g. a frame from a prior state): the FSM waits in IDLE and does not launch.
- **Reset mid-frame:** returns to IDLE and the queue content is discarded.

Optional Feature:
- Macro: SYS_TX_QUEUE_DROP_CNT_EN.
- **When defined:**
  - Adds an output port DROP_CNT, 8 bits, reset 0.
  - DROP_CNT increments on every write dropped due to FULL and saturates at 255.
  - DROP_CNT is cleared only by RST.
- **When undefined:** the port and counter are absent and dropped writes are silent.

Decomposition:
- **Shared package:**
  - FSM state encoding: IDLE=2'b00, LAUNCH=2'b01, WAIT_BUSY=2'b10, WAIT_DONE=2'b11.
  - Default DATA_WIDTH and BUSY_TIMEOUT constants.
- **Sub-module sync_fifo_core:**
  - Owns the storage array, pointers, FULL, EMPTY and LEVEL.
  - Single clock, same reset as this block.
- **Top level:** the sequencer FSM and the timeout counter.

Test Plan:
- **Basic launch:** reset, then write 0xA5 with TX_BUSY=0 → TX_VLD=1 for one cycle, 2 edges after the write, with TX_DATA=0xA5; LEVEL returns to 0. Then drive TX_BUSY high for 10 cycles, then low → FSM returns to IDLE.
- **Fill and overflow:** write 0x01..0x09 back-to-back with TX_BUSY held 1 → FULL after the 8th write, LEVEL=8, 0x09 dropped. With the macro: DROP_CNT=1.
- **Ordered drain:** on the filled queue, toggle TX_BUSY per frame → TX_VLD pulses carry 0x01..0x08 in order; no pulse while TX_BUSY=1; EMPTY=1 at the end.
- **Busy timeout:** write 0x3C and keep TX_BUSY=0 → one TX_VLD, then TIMEOUT pulse exactly BUSY_TIMEOUT cycles later. A second byte 0x3D then launches normally.
- **Simultaneous write and pop:** at LEVEL=3, write during the LAUNCH cycle → LEVEL stays 3 and the order is preserved.
- **Reset mid-frame:** assert RST during WAIT_DONE with LEVEL=4 → all outputs at reset values immediately; no TX_VLD after release until a new write.
